// File: rtl/mvu_hpbank_reader.sv
// mvu_hpbank_reader
//
// Streaming read engine for the MVU high-precision data bank. A start pulse
// launches a strided walk (base, base+stride, ...) of `length` one-word reads
// into the fixed-latency bank port. Returned words land in a credit-managed
// buffer and leave on a registered valid/ready stream with a last marker.
//
// Ports
//   clk_i            sole clock, rising edge
//   rst_ni           synchronous active-low reset
//   start_i          one-cycle transfer request, honoured only while idle
//   base_addr_i      first read address
//   stride_i         unsigned address increment per word (wraps mod 2^BADDR)
//   length_i         words to transfer, 0 = empty transfer
//   busy_o           transfer in progress (issuing or draining)
//   done_o           one-cycle pulse when a transfer completes
//   mem_rd_en_o      bank read strobe
//   mem_rd_addr_o    bank read address
//   mem_rd_data_i    bank read data, valid RDLAT cycles after the strobe
//   out_valid_o      output word available
//   out_data_o       output word
//   out_last_o       marks the final word of a transfer
//   out_ready_i      consumer accept
//
// Buffering: the output register plus a (DEPTH-1)-entry FIFO together hold
// DEPTH words. A read is issued only when every word already stored or still
// in flight, minus the one leaving this cycle, leaves room for it, so the
// buffer can never overflow. DEPTH must be at least RDLAT+2 for full rate.

module mvu_hpbank_reader #(
  parameter int unsigned BADDR = 12,
  parameter int unsigned BWORD = 32,
  parameter int unsigned BLEN  = 12,
  parameter int unsigned RDLAT = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [BADDR-1:0] base_addr_i,
  input  logic [BADDR-1:0] stride_i,
  input  logic [BLEN-1:0]  length_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mem_rd_en_o,
  output logic [BADDR-1:0] mem_rd_addr_o,
  input  logic [BWORD-1:0] mem_rd_data_i,
  output logic             out_valid_o,
  output logic [BWORD-1:0] out_data_o,
  output logic             out_last_o,
  input  logic             out_ready_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  // FIFO behind the output register
  localparam int unsigned FD = DEPTH - 1;
  localparam int unsigned PW = (FD > 1) ? $clog2(FD) : 1;
  // Wide enough for occupancy + in-flight (<= DEPTH + RDLAT) and DEPTH + 1
  localparam int unsigned CW = $clog2(DEPTH + RDLAT + 2);

  // Control state
  logic [1:0]       state_q, state_d;
  logic [BADDR-1:0] addr_q, addr_d;
  logic [BADDR-1:0] stride_q, stride_d;
  logic [BLEN-1:0]  len_q, len_d;
  logic [BLEN-1:0]  cnt_q, cnt_d;

  // In-flight tracking: one bit per outstanding bank read, plus its last flag
  logic [RDLAT-1:0] vld_q, vld_d;
  logic [RDLAT-1:0] lst_q, lst_d;

  // Word buffer
  logic [BWORD-1:0] fifo_data_q [FD];
  logic             fifo_last_q [FD];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;

  // Registered output stage
  logic             out_valid_q, out_valid_d;
  logic [BWORD-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  // Datapath strobes
  logic          pop;
  logic          rd_en;
  logic          last_rd;
  logic          credit_ok;
  logic [CW-1:0] inflight;
  logic [CW-1:0] occ;
  logic          in_vld;
  logic          in_last;
  logic          load;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          fifo_push;
  logic          bypass;

  //--------------------------------------------------------------------------
  // Credit check
  //--------------------------------------------------------------------------
  assign pop = out_valid_q & out_ready_i;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RDLAT; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
  end

  assign occ = fifo_cnt_q + CW'(out_valid_q);

  // occ + inflight - pop < DEPTH, rearranged to avoid underflow
  assign credit_ok = (occ + inflight) < (CW'(DEPTH) + CW'(pop));
  assign rd_en     = (state_q == StIssue) && credit_ok;
  assign last_rd   = rd_en && (cnt_q == (len_q - BLEN'(1)));

  //--------------------------------------------------------------------------
  // Transfer FSM
  //--------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (length_i != '0) begin
            state_d  = StIssue;
            addr_d   = base_addr_i;
            stride_d = stride_i;
            len_d    = length_i;
            cnt_d    = '0;
          end else begin
            state_d = StFin;
          end
        end
      end
      StIssue: begin
        if (rd_en) begin
          addr_d = addr_q + stride_q;
          cnt_d  = cnt_q + BLEN'(1);
          if (last_rd) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && out_last_q) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Bank-latency shift: bit RDLAT-1 marks data present on mem_rd_data_i now
  //--------------------------------------------------------------------------
  always_comb begin
    vld_d    = '0;
    lst_d    = '0;
    vld_d[0] = rd_en;
    lst_d[0] = last_rd;
    for (int unsigned i = 1; i < RDLAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
  end

  assign in_vld  = vld_q[RDLAT-1];
  assign in_last = lst_q[RDLAT-1];

  //--------------------------------------------------------------------------
  // Buffer and output register
  //--------------------------------------------------------------------------
  assign load       = !out_valid_q || pop;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_pop   = load && !fifo_empty;
  // An arriving word skips the FIFO only when nothing older is queued
  assign bypass     = load && fifo_empty && in_vld;
  assign fifo_push  = in_vld && !bypass;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load) begin
      if (!fifo_empty) begin
        out_valid_d = 1'b1;
        out_data_d  = fifo_data_q[rd_ptr_q];
        out_last_d  = fifo_last_q[rd_ptr_q];
      end else if (in_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_rd_data_i;
        out_last_d  = in_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    if (fifo_push) begin
      wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      lst_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      lst_q       <= lst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Storage array needs no reset: the pointers and count define its contents
  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_data_q[wr_ptr_q] <= mem_rd_data_i;
      fifo_last_q[wr_ptr_q] <= in_last;
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign busy_o        = (state_q == StIssue) || (state_q == StDrain);
  assign done_o        = (state_q == StFin);
  assign mem_rd_en_o   = rd_en;
  assign mem_rd_addr_o = addr_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_last_o    = out_last_q;

endmodule

// File: doc/mvu_hpbank_reader.md
# mvu_hpbank_reader

Streaming read engine for the MVU high-precision data bank. On a start pulse it walks a strided address sequence (base, stride, length) and issues one-word reads into the fixed-latency bank port. It buffers returned words in a credit-managed FIFO and presents them on a valid/ready output stream to the host/DMA side. It is the read-out counterpart of the scaler/bias write path that fills the high-precision bank.

## Interface
- BADDR, 12, bank address width (matches BDHPBANKA)
- BWORD, 32, word width (matches BDHPBANKW)
- BLEN, 12, transfer length width (words)
- RDLAT, 2, bank read latency in cycles (matches MEMRDLATENCY)
- DEPTH, 4, output FIFO depth; must be ≥ RDLAT+2
- clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  BADDR  first read address
- stride  in  BADDR  address increment per word (unsigned)
- length  in  BLEN  words to transfer; 0 = empty transfer
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at transfer end
- mem_rd_en  out  1  bank read strobe
- mem_rd_addr  out  BADDR  bank read address
- mem_rd_data  in  BWORD  valid exactly RDLAT cycles after the mem_rd_en cycle
- out_valid  out  1  output word available
- out_data  out  BWORD  output word
- out_last  out  1  qualifies the final word of a transfer
- out_ready  in  1  consumer accept

## Operation
- States:
  - IDLE: start with length≠0 latches base/stride/length and moves to ISSUE. start with length=0 moves to FIN.
  - ISSUE: issues reads; after the length-th read moves to DRAIN.
  - DRAIN: waits until the final word's handshake, then moves to FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Addresses are base, base+stride, base+2·stride, …, computed modulo 2^BADDR (silent wrap).
- Credits: a read issues in a cycle iff in ISSUE and fifo_count + inflight − (out_valid&out_ready) < DEPTH.
  - inflight = reads issued but not yet returned (0..RDLAT).
  - A full FIFO therefore never overflows and never drops a word.
- Returned data is written into the FIFO at cycle issue+RDLAT, tracked by a RDLAT-deep valid shift register. The FIFO stores last alongside data.
- Output is registered (no fall-through). out_data/out_last hold stable while out_valid & !out_ready.
- start is ignored outside IDLE; the latched parameters do not change mid-transfer.
- Reset while busy:
  - Everything returns to IDLE; FIFO is emptied; the in-flight valid shift is cleared.
  - Bank data returning after reset is discarded.
  - No done is produced for the aborted transfer.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0.

## Timing
- start sampled at edge T → busy=1 and the first mem_rd_en at cycle T+1.
- First out_valid at cycle T+1+RDLAT+1 (RDLAT+2 cycles after start).
- With out_ready held high, sustained 1 word/cycle: reads issue on consecutive cycles, and a length-L transfer's last handshake falls at cycle T+RDLAT+1+L.
- done pulses in the cycle after the last handshake; busy falls in that same cycle. Earliest next accepted start is the cycle after done.
- length=0: done at T+1, busy never rises, no mem_rd_en, no out_valid.
- out_ready low: at most DEPTH words outstanding (FIFO + inflight); mem_rd_en stalls until credit frees.
- out_last=1 only with the L-th word.

## Test plan
- base=0x010, stride=1, length=8, out_ready=1 → reads at 0x010..0x017 on 8 consecutive cycles; out_data matches bank contents in order; out_last on word 8; done at T+RDLAT+2+8.
- base=0xFFE, stride=3, length=4 → addresses 0xFFE, 0x001, 0x004, 0x007 (wrap); data order preserved.
- length=16, out_ready toggled 1-of-3 cycles, plus a 20-cycle out_ready=0 hold → no loss or duplication; outstanding never exceeds 4; outputs stable while stalled.
- length=0 → single done pulse at T+1; no mem_rd_en and no out_valid at any point.
- Second start pulse while busy with different parameters → ignored; first transfer completes unchanged; exactly one done.
- rst_n=0 for one cycle mid-transfer with 2 reads in flight → all outputs 0 the next cycle; no stale words are emitted; no done; a new transfer afterwards is correct.
